// File: rtl/pe_frc_acc_multi.sv
// pe_frc_acc_multi: per-filter force accumulator slots with eviction, flush FSM and a 2-write output FIFO
module pe_frc_acc_multi #(
  parameter int NUM_REGS    = 7,
  parameter int FRC_WIDTH   = 32,
  parameter int PARID_WIDTH = 9,
  parameter int CID_WIDTH   = 9,
  parameter int NODE_WIDTH  = 4,
  parameter int OUT_DEPTH   = 8,
  parameter bit SATURATE    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_frc_valid,
  input  logic [3*FRC_WIDTH-1:0]   i_frc,
  input  logic [PARID_WIDTH-1:0]   i_parid,
  input  logic [CID_WIDTH-1:0]     i_cid,
  input  logic [NODE_WIDTH-1:0]    i_node_id,
  input  logic [NUM_REGS-1:0]      i_reg_sel,
  input  logic                     i_release,
  input  logic                     i_flush,
  output logic [3*FRC_WIDTH-1:0]   o_frc,
  output logic [PARID_WIDTH-1:0]   o_parid,
  output logic [CID_WIDTH-1:0]     o_cid,
  output logic [NODE_WIDTH-1:0]    o_node_id,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_back_pressure,
  output logic                     o_flush_done,
  output logic [2:0]               o_err
);
  localparam int TW = PARID_WIDTH + CID_WIDTH + NODE_WIDTH;
  localparam int EW = 3 * FRC_WIDTH + TW;
  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [AW:0] BP_TH = (AW + 1)'(OUT_DEPTH - 2);
  localparam logic [AW:0] FULL = (AW + 1)'(OUT_DEPTH);
  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] slot_q [NUM_REGS];
  logic [EW-1:0] slot_d [NUM_REGS];
  logic [EW-1:0] mem_q [OUT_DEPTH];
  logic [EW-1:0] mem_d [OUT_DEPTH];
  logic [NUM_REGS-1:0] occ_q, occ_d, fsel;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [2:0] err_q, err_d;
  logic [EW-1:0] cur, fent, nxt, w0;
  logic [3*FRC_WIDTH-1:0] acc;
  logic [FRC_WIDTH:0] sum_c;
  logic onehot, accept, cur_occ, match, evict, sat, fpush, pop;
  logic [1:0] np;
  // returns {overflow flag, result}; flag only raised when clamping
  function automatic logic [FRC_WIDTH:0] add_c(input logic [FRC_WIDTH-1:0] a, input logic [FRC_WIDTH-1:0] b);
    logic [FRC_WIDTH:0] s;
    logic ovf;
    s = {a[FRC_WIDTH-1], a} + {b[FRC_WIDTH-1], b};
    ovf = SATURATE && (s[FRC_WIDTH] ^ s[FRC_WIDTH-1]);
    return {ovf, ovf ? {s[FRC_WIDTH], {(FRC_WIDTH-1){~s[FRC_WIDTH]}}} : s[FRC_WIDTH-1:0]};
  endfunction
  assign o_valid = cnt_q != '0;
  assign o_back_pressure = cnt_q >= BP_TH || state_q != IDLE;
  assign o_flush_done = state_q == DONE;
  assign o_err = err_q;
  assign {o_frc, o_parid, o_cid, o_node_id} = mem_q[rd_q];
  // slot update, eviction/release/flush pushes, FIFO bookkeeping and FSM next state
  always_comb begin
    onehot = i_reg_sel != '0 && (i_reg_sel & (i_reg_sel - NUM_REGS'(1))) == '0;
    accept = i_frc_valid && !o_back_pressure && onehot;
    pop = o_valid && i_ready;
    cur = '0;
    fent = '0;
    fsel = occ_q & (~occ_q + NUM_REGS'(1));
    for (int k = 0; k < NUM_REGS; k++) begin
      cur |= i_reg_sel[k] ? slot_q[k] : '0;
      fent |= fsel[k] ? slot_q[k] : '0;
    end
    cur_occ = |(occ_q & i_reg_sel);
    match = cur_occ && cur[TW-1:NODE_WIDTH] == {i_parid, i_cid};
    acc = '0;
    sum_c = '0;
    sat = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sum_c = add_c(cur[TW + c*FRC_WIDTH +: FRC_WIDTH], i_frc[c*FRC_WIDTH +: FRC_WIDTH]);
      acc[c*FRC_WIDTH +: FRC_WIDTH] = sum_c[FRC_WIDTH-1:0];
      sat |= sum_c[FRC_WIDTH];
    end
    nxt = match ? {acc, cur[TW-1:0]} : {i_frc, i_parid, i_cid, i_node_id};
    evict = accept && cur_occ && !match;
    fpush = state_q == FLUSH && occ_q != '0 && (cnt_q < FULL || pop);
    slot_d = slot_q;
    occ_d = fpush ? occ_q & ~fsel : occ_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (accept && i_reg_sel[k]) begin
        slot_d[k] = nxt;
        occ_d[k] = !i_release;
      end
    end
    w0 = evict ? cur : fpush ? fent : nxt;
    np = 2'(evict) + 2'(accept && i_release) + 2'(fpush);
    mem_d = mem_q;
    if (np != 2'd0) mem_d[wr_q] = w0;
    if (np == 2'd2) mem_d[wr_q + AW'(1)] = nxt;
    wr_d = wr_q + AW'(np);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW + 1)'(np) - (AW + 1)'(pop);
    err_d = err_q | {accept && match && sat, i_frc_valid && o_back_pressure, i_frc_valid && !onehot};
    state_d = state_q == IDLE ? (i_flush ? FLUSH : IDLE) :
              state_q == FLUSH ? (occ_d == '0 ? DONE : FLUSH) : IDLE;
  end
  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q <= '{default: '0};
      occ_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      occ_q <= occ_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  // FIFO storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: tb/tb_pe_frc_acc_multi.sv
// tb_pe_frc_acc_multi: scoreboard bench with a behavioural slot/FIFO model
module tb_pe_frc_acc_multi;
  localparam int NR = 7;
  localparam int D = 8;
  localparam bit SAT = 1'b1;
  localparam longint MAXV = 2147483647;
  localparam longint MINV = -MAXV - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid, rel, flush, ready;
  logic [95:0] frc;
  logic [8:0] parid, cid;
  logic [3:0] node;
  logic [NR-1:0] sel;
  logic [95:0] o_frc, w_frc;
  logic [8:0] o_parid, o_cid, w_parid, w_cid;
  logic [3:0] o_node, w_node;
  logic o_valid, o_bp, o_done, w_valid, w_bp, w_done;
  logic [2:0] o_err, w_err;
  int vectors = 0;
  int miscompares = 0;
  logic [117:0] exp_q[$];
  int msum [NR][3];
  int mpar [NR];
  int mcid [NR];
  int mnode [NR];
  logic [NR-1:0] mocc;
  int mcnt, mph, np;
  logic [2:0] merr;

  pe_frc_acc_multi dut (
    .clk(clk), .rst(rst), .i_frc_valid(valid), .i_frc(frc), .i_parid(parid), .i_cid(cid),
    .i_node_id(node), .i_reg_sel(sel), .i_release(rel), .i_flush(flush), .o_frc(o_frc),
    .o_parid(o_parid), .o_cid(o_cid), .o_node_id(o_node), .o_valid(o_valid), .i_ready(ready),
    .o_back_pressure(o_bp), .o_flush_done(o_done), .o_err(o_err));

  pe_frc_acc_multi #(.SATURATE(1'b0)) dut_w (
    .clk(clk), .rst(rst), .i_frc_valid(valid), .i_frc(frc), .i_parid(parid), .i_cid(cid),
    .i_node_id(node), .i_reg_sel(sel), .i_release(rel), .i_flush(flush), .o_frc(w_frc),
    .o_parid(w_parid), .o_cid(w_cid), .o_node_id(w_node), .o_valid(w_valid), .i_ready(ready),
    .o_back_pressure(w_bp), .o_flush_done(w_done), .o_err(w_err));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [117:0] mk(int k);
    return {msum[k][2], msum[k][1], msum[k][0], mpar[k][8:0], mcid[k][8:0], mnode[k][3:0]};
  endfunction

  function automatic int addf(int a, int b);
    longint v;
    v = longint'(a) + longint'(b);
    if (SAT && v > MAXV) begin merr[2] = 1'b1; return int'(MAXV); end
    if (SAT && v < MINV) begin merr[2] = 1'b1; return int'(MINV); end
    return int'(v);
  endfunction

  task automatic push(int k);
    exp_q.push_back(mk(k));
    np++;
  endtask

  task automatic model_step();
    bit pop, bp, ok;
    int k;
    pop = mcnt > 0 && ready;
    bp = mcnt >= D - 2 || mph != 0;
    ok = $countones(sel) == 1;
    np = 0;
    if (valid && bp) merr[1] = 1'b1;
    if (valid && !ok) merr[0] = 1'b1;
    if (mph == 0) begin
      if (valid && !bp && ok) begin
        k = 0;
        for (int i = 0; i < NR; i++) if (sel[i]) k = i;
        if (mocc[k] && mpar[k] == int'(parid) && mcid[k] == int'(cid)) begin
          for (int c = 0; c < 3; c++) msum[k][c] = addf(msum[k][c], frc[c*32 +: 32]);
        end else begin
          if (mocc[k]) push(k);
          for (int c = 0; c < 3; c++) msum[k][c] = frc[c*32 +: 32];
          mpar[k] = int'(parid);
          mcid[k] = int'(cid);
          mnode[k] = int'(node);
        end
        mocc[k] = 1'b1;
        if (rel) begin push(k); mocc[k] = 1'b0; end
      end
      if (flush) mph = 1;
    end else if (mph == 1) begin
      k = -1;
      for (int i = NR - 1; i >= 0; i--) if (mocc[i]) k = i;
      if (k >= 0 && (mcnt < D || pop)) begin push(k); mocc[k] = 1'b0; end
      if (mocc == '0) mph = 2;
    end else mph = 0;
    mcnt = mcnt + np - int'(pop);
  endtask

  task automatic tick();
    chk("o_valid", o_valid, mcnt > 0);
    chk("o_back_pressure", o_bp, mcnt >= D - 2 || mph != 0);
    chk("o_flush_done", o_done, mph == 2);
    chk("o_err", o_err, merr);
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    valid = 1'b0; rel = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic beat(int k, int p, int x, bit r);
    valid = 1'b1; sel = NR'(1 << k); parid = 9'(p); cid = 9'd3; node = 4'(k);
    frc = {32'd0, 32'd0, 32'(x)}; rel = r;
    tick();
    valid = 1'b0; rel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; rel = 1'b0; flush = 1'b0; ready = 1'b0;
    sel = '0; frc = '0; parid = '0; cid = '0; node = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    mocc = '0; mcnt = 0; mph = 0; merr = '0; exp_q.delete();
    for (int k = 0; k < NR; k++) begin
      msum[k] = '{0, 0, 0};
      mpar[k] = 0; mcid[k] = 0; mnode[k] = 0;
    end
  endtask

  // scoreboard monitor: every handshake pops the oldest expected entry
  always @(negedge clk) begin
    if (!rst && o_valid && ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL fifo_out: got %0h expected nothing", {o_frc, o_parid, o_cid, o_node});
      end else chk("fifo_out", {o_frc, o_parid, o_cid, o_node}, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    do_reset();
    idle(1);
    ready = 1'b1;
    beat(2, 10, 5, 0);
    beat(2, 10, 7, 0);
    beat(2, 10, -3, 1);
    chk("t1 valid after release", o_valid, 1);
    chk("t1 x", o_frc[31:0], 32'd9);
    idle(3);
    beat(0, 4, 1, 0);
    beat(0, 6, 2, 1);
    chk("t2 first parid", o_parid, 9'd4);
    idle(3);
    beat(0, 1, 32'h7FFFFFF0, 0);
    beat(0, 1, 32'h20, 1);
    chk("t3 sat x", o_frc[31:0], 32'h7FFFFFFF);
    chk("t3 wrap x", w_frc[31:0], 32'h80000010);
    chk("t3 wrap no flag", w_err[2], 1'b0);
    idle(3);
    ready = 1'b0;
    for (int i = 0; i < D - 2; i++) beat(0, 20 + i, i + 1, 1);
    chk("t4 back pressure", o_bp, 1'b1);
    beat(1, 30, 99, 1);
    chk("t4 drop flag", o_err[1], 1'b1);
    ready = 1'b1;
    idle(D + 2);
    do_reset();
    ready = 1'b1;
    beat(1, 11, 1, 0);
    beat(3, 13, 3, 0);
    beat(6, 16, 6, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n = 1;
    while (!o_done && n < 20) begin tick(); n++; end
    chk("t5 flush_done latency", n, 4);
    idle(3);
    valid = 1'b1; sel = 7'b0000101; parid = 9'd5; frc = 96'd7;
    tick();
    valid = 1'b0;
    chk("t6 bad sel flag", o_err[0], 1'b1);
    beat(0, 1, 1, 0);
    beat(1, 2, 2, 0);
    beat(2, 3, 3, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    do_reset();
    chk("t6 rst valid", o_valid, 1'b0);
    chk("t6 rst bp", o_bp, 1'b0);
    chk("t6 rst err", o_err, 3'b000);
    chk("t6 rst done", o_done, 1'b0);
    for (int i = 0; i < 600; i++) begin
      valid = $urandom_range(0, 9) < 6;
      sel = $urandom_range(0, 9) == 0 ? NR'($urandom_range(0, 127)) : NR'(1 << $urandom_range(0, NR - 1));
      parid = 9'($urandom_range(1, 3));
      cid = 9'($urandom_range(0, 1));
      node = 4'($urandom_range(0, 15));
      for (int c = 0; c < 3; c++)
        frc[c*32 +: 32] = $urandom_range(0, 19) == 0 ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
      rel = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 49) == 0;
      ready = $urandom_range(0, 9) < 7;
      tick();
    end
    ready = 1'b1;
    valid = 1'b0; rel = 1'b0; flush = 1'b0;
    for (int i = 0; i < 40 && (mcnt > 0 || mph != 0); i++) tick();
    idle(2);
    chk("drain queue empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
